// File: rtl/wdt_config_regfile.sv
// Watchdog configuration register file.
// Each channel has four 16-bit registers: FWLEN, SWLEN, SERVICE and RST_LMT.
// Writes are accepted only inside a timed unlock window. The window opens
// after the two-key sequence KEY1 then KEY2.
// While the file is locked, writes to SERVICE may still kick the watchdog
// through the WDSRVC bit (bit 3). Other locked writes are rejected and counted
// as errors.
module wdt_config_regfile #(
  parameter int          CHW        = 1,
  parameter logic [15:0] FWLEN_DEF  = 16'h00FF,
  parameter logic [15:0] SWLEN_DEF  = 16'h000A,
  parameter logic [15:0] SVC_DEF    = 16'h0010,
  parameter logic [15:0] RSTLMT_DEF = 16'h0000,
  parameter logic [15:0] KEY1       = 16'hA5A5,
  parameter logic [15:0] KEY2       = 16'h5A5A,
  parameter int          UNLOCK_CYC = 16,
  localparam int         NCH        = 2**CHW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wren_i,
  input  logic              rden_i,
  input  logic              keywr_i,
  input  logic [CHW+1:0]    abus_i,
  input  logic [15:0]       dbus_i,
  output logic [15:0]       rdata_o,
  output logic              rvalid_o,
  output logic [16*NCH-1:0] fwlen_o,
  output logic [16*NCH-1:0] swlen_o,
  output logic [16*NCH-1:0] rstlmt_o,
  output logic [NCH-1:0]    init_o,
  output logic [NCH-1:0]    wdsrvc_o,
  output logic [3*NCH-1:0]  flstat_o,
  output logic              locked_o,
  output logic              werr_o,
  output logic [7:0]        errcnt_o
);

  typedef enum logic [1:0] {ST_LOCKED, ST_ARMED, ST_UNLOCKED} state_e;

  localparam logic [7:0] UNLOCK_LOAD = 8'(UNLOCK_CYC);

  // The declaration initialisers give the same values at power-up as after a reset.
  state_e      state_q = ST_LOCKED;
  state_e      state_d;
  logic [7:0]  timer_q = '0;
  logic [7:0]  timer_d;
  logic [15:0] fwlen_q  [NCH] = '{default: FWLEN_DEF};
  logic [15:0] swlen_q  [NCH] = '{default: SWLEN_DEF};
  logic [15:0] svc_q    [NCH] = '{default: SVC_DEF};
  logic [15:0] rstlmt_q [NCH] = '{default: RSTLMT_DEF};
  logic [15:0] fwlen_d  [NCH];
  logic [15:0] swlen_d  [NCH];
  logic [15:0] svc_d    [NCH];
  logic [15:0] rstlmt_d [NCH];
  logic [15:0] rdata_q  = '0;
  logic        rvalid_q = 1'b0;
  logic        werr_q   = 1'b0;
  logic [7:0]  errcnt_q = '0;
  logic [7:0]  errcnt_d;
  logic [15:0] rd_sel;
  logic        key_err;
  logic        wr_err;
  logic        unlocked;

  logic [CHW-1:0] ch_sel;
  logic [1:0]     reg_sel;

  assign ch_sel   = abus_i[CHW+1:2];
  assign reg_sel  = abus_i[1:0];
  assign unlocked = (state_q == ST_UNLOCKED);

  // Key sequence and unlock timer. Any key write during the window relocks the file without counting an error.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    key_err = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (keywr_i) begin
          if (dbus_i == KEY1) state_d = ST_ARMED;
          else                key_err = 1'b1;
        end
      end
      ST_ARMED: begin
        if (keywr_i) begin
          if (dbus_i == KEY2) begin
            state_d = ST_UNLOCKED;
            timer_d = UNLOCK_LOAD;
          end else begin
            state_d = ST_LOCKED;
            key_err = 1'b1;
          end
        end
      end
      ST_UNLOCKED: begin
        if (keywr_i || timer_q <= 8'd1) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_LOCKED;
        timer_d = '0;
      end
    endcase
  end

  // Register writes are judged against the pre-edge lock state. WDSRVC self-clears unless it is rewritten with 1.
  always_comb begin
    fwlen_d  = fwlen_q;
    swlen_d  = swlen_q;
    svc_d    = svc_q;
    rstlmt_d = rstlmt_q;
    wr_err   = 1'b0;
    for (int c = 0; c < NCH; c++) svc_d[c][3] = 1'b0;
    if (wren_i) begin
      if (unlocked) begin
        case (reg_sel)
          2'd0:    fwlen_d[ch_sel]  = dbus_i;
          2'd1:    swlen_d[ch_sel]  = dbus_i;
          2'd2:    svc_d[ch_sel]    = dbus_i;
          default: rstlmt_d[ch_sel] = dbus_i;
        endcase
      end else if (reg_sel == 2'd2) begin
        svc_d[ch_sel][3] = dbus_i[3];
      end else begin
        wr_err = 1'b1;
      end
    end
  end

  // Read mux over the pre-edge register contents.
  always_comb begin
    case (reg_sel)
      2'd0:    rd_sel = fwlen_q[ch_sel];
      2'd1:    rd_sel = swlen_q[ch_sel];
      2'd2:    rd_sel = svc_q[ch_sel];
      default: rd_sel = rstlmt_q[ch_sel];
    endcase
  end

  // A rejected write and a bad key in the same cycle count as one error. The counter saturates.
  always_comb begin
    errcnt_d = errcnt_q;
    if ((key_err || wr_err) && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
  end

  // State update. Reset takes priority over every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_LOCKED;
      timer_q  <= '0;
      errcnt_q <= '0;
      werr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        fwlen_q[c]  <= FWLEN_DEF;
        swlen_q[c]  <= SWLEN_DEF;
        svc_q[c]    <= SVC_DEF;
        rstlmt_q[c] <= RSTLMT_DEF;
      end
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      errcnt_q <= errcnt_d;
      werr_q   <= key_err || wr_err;
      rvalid_q <= rden_i;
      if (rden_i) rdata_q <= rd_sel;
      fwlen_q  <= fwlen_d;
      swlen_q  <= swlen_d;
      svc_q    <= svc_d;
      rstlmt_q <= rstlmt_d;
    end
  end

  // Flatten the per-channel registers onto the output buses.
  always_comb begin
    fwlen_o  = '0;
    swlen_o  = '0;
    rstlmt_o = '0;
    init_o   = '0;
    wdsrvc_o = '0;
    flstat_o = '0;
    for (int c = 0; c < NCH; c++) begin
      fwlen_o[16*c +: 16]  = fwlen_q[c];
      swlen_o[16*c +: 16]  = swlen_q[c];
      rstlmt_o[16*c +: 16] = rstlmt_q[c];
      init_o[c]            = svc_q[c][4];
      wdsrvc_o[c]          = svc_q[c][3];
      flstat_o[3*c +: 3]   = svc_q[c][2:0];
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign locked_o = !unlocked;
  assign werr_o   = werr_q;
  assign errcnt_o = errcnt_q;

endmodule
